mc_controller: RTL and testbench



---
 rtl/mc_controller.sv | 140 ++++++++++++++
 tb/tb_mc_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS main controller sequencing IF/ID/EX/MEM/WB plus a timed MD busy state for mult/div.
module mc_controller #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       PC_WE,
   output logic       IR_WE,
   output logic [1:0] NPC_SEL,
   output logic       GRF_WE,
   output logic [1:0] GRF_A3_MUX,
   output logic [2:0] GRF_WD_MUX,
   output logic       ALU_B_MUX,
   output logic [1:0] ALUOp,
   output logic [1:0] EXTOp,
   output logic       DM_WE,
   output logic       MD_START,
   output logic       MD_OP,
   output logic       HILO_WE,
   output logic       busy,
   output logic [2:0] state
);
   typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_MD = 3'd5} state_e;
   state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic r_type, is_addu, is_subu, is_jr, is_mult, is_div, is_mfhi, is_mflo;
   logic is_ori, is_lw, is_sw, is_beq, is_lui, is_jal, is_mem, is_md, to_ex;
   assign r_type  = opcode == 6'h00;
   assign is_addu = r_type && funct == 6'h21;
   assign is_subu = r_type && funct == 6'h23;
   assign is_jr   = r_type && funct == 6'h08;
   assign is_mult = r_type && funct == 6'h18;
   assign is_div  = r_type && funct == 6'h1A;
   assign is_mfhi = r_type && funct == 6'h10;
   assign is_mflo = r_type && funct == 6'h12;
   assign is_ori  = opcode == 6'h0D;
   assign is_lw   = opcode == 6'h23;
   assign is_sw   = opcode == 6'h2B;
   assign is_beq  = opcode == 6'h04;
   assign is_lui  = opcode == 6'h0F;
   assign is_jal  = opcode == 6'h03;
   assign is_mem  = is_lw || is_sw;
   assign is_md   = is_mult || is_div;
   assign to_ex   = is_addu || is_subu || is_ori || is_lui || is_mem || is_beq || is_md;
   assign state   = state_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IF;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   always_comb begin
      state_d    = S_IF;
      cnt_d      = cnt_q;
      PC_WE      = 1'b0;
      IR_WE      = 1'b0;
      NPC_SEL    = 2'd0;
      GRF_WE     = 1'b0;
      GRF_A3_MUX = 2'd0;
      GRF_WD_MUX = 3'd0;
      ALU_B_MUX  = 1'b0;
      ALUOp      = 2'd0;
      EXTOp      = 2'd0;
      DM_WE      = 1'b0;
      MD_START   = 1'b0;
      MD_OP      = 1'b0;
      HILO_WE    = 1'b0;
      busy       = 1'b0;
      case (state_q)
         S_IF: begin
            IR_WE   = 1'b1;
            PC_WE   = 1'b1;
            state_d = S_ID;
         end
         S_ID: begin
            PC_WE      = is_jal || is_jr;
            NPC_SEL    = is_jal ? 2'd2 : is_jr ? 2'd3 : 2'd0;
            GRF_WE     = is_jal;
            GRF_A3_MUX = is_jal ? 2'd2 : 2'd0;
            GRF_WD_MUX = is_jal ? 3'd3 : 3'd0;
            state_d    = (is_mfhi || is_mflo) ? S_WB : to_ex ? S_EX : S_IF;
         end
         S_EX: begin
            ALUOp     = (is_subu || is_beq) ? 2'd1 : is_ori ? 2'd2 : 2'd0;
            ALU_B_MUX = is_ori || is_mem;
            EXTOp     = is_lui ? 2'd2 : is_mem ? 2'd1 : 2'd0;
            PC_WE     = is_beq && zero;
            NPC_SEL   = (is_beq && zero) ? 2'd1 : 2'd0;
            MD_START  = is_md;
            MD_OP     = is_div;
            cnt_d     = is_div ? CNT_W'(DIV_CYCLES - 1) : is_mult ? CNT_W'(MULT_CYCLES - 1) : cnt_q;
            state_d   = is_mem ? S_MEM : is_md ? S_MD : is_beq ? S_IF : S_WB;
         end
         S_MEM: begin
            ALU_B_MUX = 1'b1;
            EXTOp     = 2'd1;
            DM_WE     = is_sw;
            state_d   = is_lw ? S_WB : S_IF;
         end
         S_WB: begin
            GRF_WE     = 1'b1;
            GRF_A3_MUX = (is_ori || is_lui || is_lw) ? 2'd1 : 2'd0;
            GRF_WD_MUX = is_lw ? 3'd1 : is_lui ? 3'd2 : is_mfhi ? 3'd4 : is_mflo ? 3'd5 : 3'd0;
         end
         S_MD: begin
            busy    = 1'b1;
            MD_OP   = is_div;
            HILO_WE = cnt_q == '0;
            cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
            state_d = cnt_q == '0 ? S_IF : S_MD;
         end
         default: state_d = S_IF;
      endcase
      // reset forces every control quiet, even though the state register already reads IF
      if (!reset) begin
         PC_WE      = 1'b0;
         IR_WE      = 1'b0;
         NPC_SEL    = 2'd0;
         GRF_WE     = 1'b0;
         GRF_A3_MUX = 2'd0;
         GRF_WD_MUX = 3'd0;
         ALU_B_MUX  = 1'b0;
         ALUOp      = 2'd0;
         EXTOp      = 2'd0;
         DM_WE      = 1'b0;
         MD_START   = 1'b0;
         MD_OP      = 1'b0;
         HILO_WE    = 1'b0;
         busy       = 1'b0;
      end
   end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed plus random instruction streams checked cycle by cycle against a per-instruction expected-control list.
module tb_mc_controller;
   typedef struct packed {
      logic [2:0] st;
      logic       pc_we;
      logic       ir_we;
      logic [1:0] npc;
      logic       grf_we;
      logic [1:0] a3;
      logic [2:0] wd;
      logic       bmux;
      logic [1:0] alu;
      logic [1:0] ext;
      logic       dm_we;
      logic       md_start;
      logic       md_op;
      logic       hilo_we;
      logic       busy;
   } vec_t;
   localparam int ADDU = 0, SUBU = 1, JR = 2, MULT = 3, DIV = 4, MFHI = 5, MFLO = 6, ORI = 7;
   localparam int LW = 8, SW = 9, BEQ = 10, LUI = 11, JAL = 12, UNDEF = 13, RNOP = 14;
   localparam int M_CYC = 1, D_CYC = 10;
   logic       clk, reset, zero;
   logic [5:0] opcode, funct;
   logic       PC_WE, IR_WE, GRF_WE, ALU_B_MUX, DM_WE, MD_START, MD_OP, HILO_WE, busy;
   logic [1:0] NPC_SEL, GRF_A3_MUX, ALUOp, EXTOp;
   logic [2:0] GRF_WD_MUX, state;
   vec_t       act;
   vec_t       q[$];
   int         checks = 0, failures = 0;
   logic [5:0] op_tab[15] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h03, 6'h3F, 6'h00};
   logic [5:0] fn_tab[15] = '{6'h21, 6'h23, 6'h08, 6'h18, 6'h1A, 6'h10, 6'h12, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
   mc_controller #(.MULT_CYCLES(M_CYC), .DIV_CYCLES(D_CYC), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .PC_WE(PC_WE), .IR_WE(IR_WE), .NPC_SEL(NPC_SEL), .GRF_WE(GRF_WE),
      .GRF_A3_MUX(GRF_A3_MUX), .GRF_WD_MUX(GRF_WD_MUX), .ALU_B_MUX(ALU_B_MUX),
      .ALUOp(ALUOp), .EXTOp(EXTOp), .DM_WE(DM_WE), .MD_START(MD_START),
      .MD_OP(MD_OP), .HILO_WE(HILO_WE), .busy(busy), .state(state)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   assign act = {state, PC_WE, IR_WE, NPC_SEL, GRF_WE, GRF_A3_MUX, GRF_WD_MUX, ALU_B_MUX,
                 ALUOp, EXTOp, DM_WE, MD_START, MD_OP, HILO_WE, busy};
   function automatic vec_t blank(input logic [2:0] s);
      vec_t v;
      v = '0;
      v.st = s;
      return v;
   endfunction
   task automatic check(input string tag, input vec_t e);
      checks++;
      assert (act === e) else begin
         failures++;
         $error("FAIL %s got=%h want=%h", tag, act, e);
      end
   endtask
   // Expected control word for every cycle of one instruction, from fetch to its last cycle.
   task automatic gen(input int k, input logic z);
      vec_t e;
      int n;
      q.delete();
      e = blank(0); e.pc_we = 1; e.ir_we = 1; q.push_back(e);
      e = blank(1);
      if (k == JAL) begin e.pc_we = 1; e.npc = 2; e.grf_we = 1; e.a3 = 2; e.wd = 3; q.push_back(e); return; end
      if (k == JR) begin e.pc_we = 1; e.npc = 3; q.push_back(e); return; end
      q.push_back(e);
      if (k == UNDEF || k == RNOP) return;
      if (k == MFHI || k == MFLO) begin
         e = blank(4); e.grf_we = 1; e.wd = (k == MFHI) ? 3'd4 : 3'd5; q.push_back(e); return;
      end
      e = blank(2);
      case (k)
         SUBU: e.alu = 1;
         ORI: begin e.bmux = 1; e.alu = 2; end
         LUI: e.ext = 2;
         LW, SW: begin e.bmux = 1; e.ext = 1; end
         BEQ: begin e.alu = 1; e.pc_we = z; e.npc = z ? 2'd1 : 2'd0; end
         MULT, DIV: begin e.md_start = 1; e.md_op = (k == DIV); end
         default: ;
      endcase
      q.push_back(e);
      if (k == BEQ) return;
      if (k == LW || k == SW) begin
         e = blank(3); e.bmux = 1; e.ext = 1; e.dm_we = (k == SW); q.push_back(e);
         if (k == SW) return;
         e = blank(4); e.grf_we = 1; e.a3 = 1; e.wd = 1; q.push_back(e); return;
      end
      if (k == MULT || k == DIV) begin
         n = (k == DIV) ? D_CYC : M_CYC;
         for (int j = 0; j < n; j++) begin
            e = blank(5); e.busy = 1; e.md_op = (k == DIV); e.hilo_we = (j == n - 1); q.push_back(e);
         end
         return;
      end
      e = blank(4); e.grf_we = 1; e.a3 = (k == ORI || k == LUI) ? 2'd1 : 2'd0; e.wd = (k == LUI) ? 3'd2 : 3'd0;
      q.push_back(e);
   endtask
   // Entered just after a rising edge; stop>0 returns at the falling edge of cycle stop-1.
   task automatic run(input int k, input logic z, input int stop, input string tag);
      vec_t e;
      int n;
      gen(k, z);
      opcode = op_tab[k];
      funct  = (op_tab[k] == 6'h00) ? fn_tab[k] : 6'($urandom);
      zero   = z;
      n = q.size();
      for (int i = 0; i < n; i++) begin
         e = q.pop_front();
         @(negedge clk);
         check($sformatf("%s_c%0d", tag, i), e);
         if (stop > 0 && i == stop - 1) return;
         @(posedge clk);
         #1;
      end
   endtask
   initial begin
      int k;
      reset = 1'b0; opcode = 6'h00; funct = 6'h21; zero = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("reset_hold", blank(0));
      reset = 1'b1;
      run(ADDU, 1'b0, 3, "addu_abort");
      #2 reset = 1'b0;
      #1 check("reset_mid_ex", blank(0));
      @(posedge clk); #1;
      check("reset_held_edge", blank(0));
      reset = 1'b1;
      run(LW, 1'b0, 0, "lw");
      run(BEQ, 1'b1, 0, "beq_taken");
      run(BEQ, 1'b0, 0, "beq_not");
      run(JAL, 1'b0, 0, "jal");
      run(DIV, 1'b0, 0, "div");
      run(MULT, 1'b0, 0, "mult");
      run(UNDEF, 1'b0, 0, "undef");
      for (int i = 0; i < 60; i++) begin
         k = int'($urandom_range(0, 14));
         run(k, 1'($urandom), 0, $sformatf("rnd%0d_k%0d", i, k));
      end
      @(negedge clk);
      check("final_if", blank(0) | vec_t'({3'd0, 1'b1, 1'b1, 18'd0}));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
